// File: rtl/camera_pattern_gen_if.sv
// camera_pattern_gen_if
//   Camera conduit bundle between the pattern generator and its sink
//   (the soc_system camera_d/fval/lval inputs).
//   cam_d     12  pixel data, 0 whenever cam_lval = 0
//   cam_fval   1  frame valid
//   cam_lval   1  line valid, only high while cam_fval = 1
//   master: the generator (drives all three); slave: the sink.
interface camera_pattern_gen_if;
  logic [11:0] cam_d;
  logic        cam_fval;
  logic        cam_lval;

  modport master (output cam_d, output cam_fval, output cam_lval);
  modport slave  (input  cam_d, input  cam_fval, input  cam_lval);
endinterface

// File: rtl/camera_pattern_gen.sv
// camera_pattern_gen
//   Emulates a 12-bit GRBG Bayer sensor with D5M-style frame/line timing so the
//   downstream edge-detection path sees deterministic frames during bring-up.
//   Every output is a register; the next-cycle values are computed together, so
//   a pixel's data appears on the same edge as its lval.
// Ports
//   clk          in   pixel clock (also fed to the camera_pixclk conduit)
//   reset        in   synchronous, active-high
//   enable       in   1 = generate frames back to back
//   pattern_sel  in   0 bars, 1 ramp, 2 checker, 3 moving diagonal
//   cam          if   master side of camera_pattern_gen_if (cam_d/fval/lval)
//   frame_count  out  completed frames, wraps 0xFFFF -> 0
//   busy         out  high from the first VBL cycle until IDLE is re-entered
module camera_pattern_gen #(
  parameter int ACTIVE_W  = 640,
  parameter int ACTIVE_H  = 480,
  parameter int HBLANK    = 160,
  parameter int VBLANK    = 45,
  parameter int FV_LEAD   = 4,
  parameter int FV_TRAIL  = 4,
  parameter int BAR_W     = 80,
  parameter int RAMP_STEP = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [1:0]                 pattern_sel,
  camera_pattern_gen_if.master       cam,
  output logic [15:0]                frame_count,
  output logic                       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_VBL, S_LEAD, S_LINE, S_HBL, S_TRAIL
  } state_e;

  // One shared blanking counter, wide enough for the longest blanking state.
  localparam int BLK_A   = (VBLANK  > HBLANK)   ? VBLANK  : HBLANK;
  localparam int BLK_B   = (FV_LEAD > FV_TRAIL) ? FV_LEAD : FV_TRAIL;
  localparam int BLK_MAX = (BLK_A   > BLK_B)    ? BLK_A   : BLK_B;
  localparam int CW      = (BLK_MAX < 1) ? 1 : $clog2(BLK_MAX + 1);
  localparam int XW      = $clog2(ACTIVE_W + 1);
  localparam int YW      = $clog2(ACTIVE_H + 1);
  localparam int BW      = (BAR_W < 2) ? 1 : $clog2(BAR_W + 1);

  // A zero VBLANK still spends one cycle in VBL so the pattern latch has a slot.
  localparam logic [CW-1:0] VBL_LAST   = CW'((VBLANK   > 0) ? VBLANK   - 1 : 0);
  localparam logic [CW-1:0] LEAD_LAST  = CW'((FV_LEAD  > 0) ? FV_LEAD  - 1 : 0);
  localparam logic [CW-1:0] HBL_LAST   = CW'((HBLANK   > 0) ? HBLANK   - 1 : 0);
  localparam logic [CW-1:0] TRAIL_LAST = CW'((FV_TRAIL > 0) ? FV_TRAIL - 1 : 0);
  localparam logic [XW-1:0] X_LAST     = XW'(ACTIVE_W - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(ACTIVE_H - 1);
  localparam logic [BW-1:0] BAR_LAST   = BW'((BAR_W > 0) ? BAR_W - 1 : 0);
  localparam logic [11:0]   STEP       = 12'(RAMP_STEP);

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] fc_lat_q, fc_lat_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic [BW-1:0] bar_pos_q, bar_pos_d;
  logic [2:0]  bar_idx_q, bar_idx_d;
  logic [11:0] ramp_q, ramp_d;
  logic [11:0] d_q, d_d;
  logic        fval_q, fval_d;
  logic        lval_q, lval_d;
  logic        busy_q, busy_d;
  logic        frame_end;
  logic        frame_start;
  logic        line_start;
  logic [2:0]  rgb;
  logic        ch_bit;
  logic [15:0] xe, ye;
  logic [11:0] pix;

  // Frame/line sequencer.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    frame_end = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_VBL;
          cnt_d   = '0;
        end
      end
      S_VBL: begin
        if (cnt_q == VBL_LAST) begin
          cnt_d   = '0;
          x_d     = '0;
          y_d     = '0;
          state_d = (FV_LEAD > 0) ? S_LEAD : S_LINE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LEAD: begin
        if (cnt_q == LEAD_LAST) begin
          cnt_d   = '0;
          x_d     = '0;
          state_d = S_LINE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LINE: begin
        if (x_q == X_LAST) begin
          x_d = '0;
          if (y_q == Y_LAST) begin
            if (FV_TRAIL > 0) begin
              state_d = S_TRAIL;
            end else begin
              frame_end = 1'b1;
              state_d   = enable ? S_VBL : S_IDLE;
            end
          end else begin
            y_d     = y_q + YW'(1);
            state_d = (HBLANK > 0) ? S_HBL : S_LINE;
          end
        end else begin
          x_d = x_q + XW'(1);
        end
      end
      S_HBL: begin
        if (cnt_q == HBL_LAST) begin
          cnt_d   = '0;
          state_d = S_LINE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_TRAIL: begin
        if (cnt_q == TRAIL_LAST) begin
          cnt_d     = '0;
          frame_end = 1'b1;
          state_d   = enable ? S_VBL : S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pattern select and frame number are frozen when the frame opens, so a
  // mid-frame pattern_sel change only affects the following frame.
  assign frame_start   = (state_q == S_VBL) && (state_d != S_VBL);
  assign sel_d         = frame_start ? pattern_sel   : sel_q;
  assign fc_lat_d      = frame_start ? frame_count_q : fc_lat_q;
  assign frame_count_d = frame_count_q + 16'(frame_end);

  // Pixel generators run one step ahead, indexed by x_d/y_d, so the data
  // register lines up with lval.
  assign line_start = (state_d == S_LINE) && (x_d == '0);

  always_comb begin
    bar_pos_d = bar_pos_q;
    bar_idx_d = bar_idx_q;
    ramp_d    = ramp_q;
    if (line_start) begin
      bar_pos_d = '0;
      bar_idx_d = '0;
      ramp_d    = '0;
    end else if (state_d == S_LINE) begin
      ramp_d = ramp_q + STEP;
      if (bar_pos_q == BAR_LAST) begin
        bar_pos_d = '0;
        bar_idx_d = (bar_idx_q == 3'd7) ? 3'd7 : bar_idx_q + 3'd1;
      end else begin
        bar_pos_d = bar_pos_q + BW'(1);
      end
    end
  end

  assign xe  = 16'(x_d);
  assign ye  = 16'(y_d);
  assign rgb = ~bar_idx_d;

  // GRBG mosaic: even rows G/R, odd rows B/G.
  always_comb begin
    case ({ye[0], xe[0]})
      2'b00:   ch_bit = rgb[1];
      2'b01:   ch_bit = rgb[2];
      2'b10:   ch_bit = rgb[0];
      default: ch_bit = rgb[1];
    endcase
  end

  always_comb begin
    case (sel_d)
      2'd0:    pix = {12{ch_bit}};
      2'd1:    pix = ramp_d;
      2'd2:    pix = (xe[3] ^ ye[3]) ? 12'hFFF : 12'h000;
      default: pix = 12'(xe + ye + fc_lat_d);
    endcase
  end

  assign fval_d = state_d inside {S_LEAD, S_LINE, S_HBL, S_TRAIL};
  assign lval_d = (state_d == S_LINE);
  assign d_d    = lval_d ? pix : 12'h000;
  assign busy_d = (state_d != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      sel_q         <= '0;
      fc_lat_q      <= '0;
      frame_count_q <= '0;
      bar_pos_q     <= '0;
      bar_idx_q     <= '0;
      ramp_q        <= '0;
      d_q           <= '0;
      fval_q        <= 1'b0;
      lval_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      sel_q         <= sel_d;
      fc_lat_q      <= fc_lat_d;
      frame_count_q <= frame_count_d;
      bar_pos_q     <= bar_pos_d;
      bar_idx_q     <= bar_idx_d;
      ramp_q        <= ramp_d;
      d_q           <= d_d;
      fval_q        <= fval_d;
      lval_q        <= lval_d;
      busy_q        <= busy_d;
    end
  end

  assign cam.cam_d    = d_q;
  assign cam.cam_fval = fval_q;
  assign cam.cam_lval = lval_q;
  assign frame_count  = frame_count_q;
  assign busy         = busy_q;

endmodule
